// File: rtl/sprite_line_fetcher.sv
// ---------------------------------------------------------------------------
// sprite_line_fetcher
//
// Purpose:
//   Owns the shared single-port sprite ROM during horizontal blanking. When
//   the raster reaches FETCH_X it snapshots the sprite table and walks the
//   slots one at a time. For every enabled sprite that covers the next scan
//   line, it reads that sprite's row from the ROM into a back buffer. At the
//   start of the next line (x == 0) the back buffer is copied into a front
//   buffer. The pixel generator only ever reads the front buffer registers.
//
// Ports:
//   clk         pixel clock
//   rst         synchronous active-high reset
//   x, y        current raster column / line
//   sprite_en   per-slot enable
//   sprite_x    slot i left edge at [16i +: 16]
//   sprite_y    slot i top edge  at [16i +: 16]
//   sprite_img  slot i image index at [IMG_W*i +: IMG_W]
//   rom_en      ROM read strobe (high only in ISSUE)
//   rom_addr    {image, row}; holds its last value between reads
//   rom_data    ROM row, valid ROM_LAT cycles after rom_en
//   line_data   front-buffer rows, slot i at [RW*i +: RW]
//   line_x      front-buffer left edges
//   line_valid  front-buffer slot i holds a row for the current line
//   busy        fetch FSM is not idle
//   overrun     sticky: a line swap happened while a fetch was still running
// ---------------------------------------------------------------------------
module sprite_line_fetcher #(
    parameter int N_SPRITES   = 4,
    parameter int SPRITE_SIZE = 40,
    parameter int BPP         = 3,
    parameter int IMG_W       = 4,
    parameter int ROW_W       = 6,
    parameter int FETCH_X     = 1920,
    parameter int V_TOTAL     = 1125,
    parameter int ROM_LAT     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [15:0]                           x,
    input  logic [15:0]                           y,
    input  logic [N_SPRITES-1:0]                  sprite_en,
    input  logic [16*N_SPRITES-1:0]               sprite_x,
    input  logic [16*N_SPRITES-1:0]               sprite_y,
    input  logic [IMG_W*N_SPRITES-1:0]            sprite_img,
    output logic                                  rom_en,
    output logic [IMG_W+ROW_W-1:0]                rom_addr,
    input  logic [SPRITE_SIZE*BPP-1:0]            rom_data,
    output logic [SPRITE_SIZE*BPP*N_SPRITES-1:0]  line_data,
    output logic [16*N_SPRITES-1:0]               line_x,
    output logic [N_SPRITES-1:0]                  line_valid,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam int RW        = SPRITE_SIZE * BPP;
    localparam int IDX_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam int WAIT_INIT = (ROM_LAT > 1) ? ROM_LAT - 2 : 0;

    localparam logic [15:0]      X_FETCH  = 16'(FETCH_X);
    localparam logic [15:0]      Y_LAST   = 16'(V_TOTAL - 1);
    localparam logic [16:0]      SIZE17   = 17'(SPRITE_SIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SPRITES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         wait_q, wait_d;

    // Set by the first fetch after reset; a reset mid-fetch clears it so no
    // swap happens until a fresh fetch has been started.
    logic               armed_q;
    logic               overrun_q;
    logic [IMG_W+ROW_W-1:0] rom_addr_q;

    // Snapshot of the sprite table and target line taken at fetch start.
    logic [15:0]        ty_q;
    logic [N_SPRITES-1:0] en_q;
    logic [15:0]        sx_q  [N_SPRITES];
    logic [15:0]        sy_q  [N_SPRITES];
    logic [IMG_W-1:0]   img_q [N_SPRITES];

    logic [RW-1:0]      back_data_q  [N_SPRITES];
    logic [15:0]        back_x_q     [N_SPRITES];
    logic [N_SPRITES-1:0] back_valid_q;
    logic [RW-1:0]      front_data_q [N_SPRITES];
    logic [15:0]        front_x_q    [N_SPRITES];
    logic [N_SPRITES-1:0] front_valid_q;

    logic               swap;
    logic               start;
    logic               load_addr;
    logic               capture;
    logic               hit;
    logic [15:0]        ty_next;
    logic [15:0]        sy_sel;
    logic [16:0]        ty17;
    logic [16:0]        sy17;
    logic [ROW_W-1:0]   row;

    assign swap    = (x == 16'd0) && armed_q;
    assign ty_next = (y == Y_LAST) ? 16'd0 : y + 16'd1;

    // The range compare is done one bit wider so a top edge near 65535 does
    // not wrap its bottom edge back past zero.
    assign sy_sel = sy_q[idx_q];
    assign ty17   = {1'b0, ty_q};
    assign sy17   = {1'b0, sy_sel};
    assign hit    = en_q[idx_q] && (ty17 >= sy17) && (ty17 < sy17 + SIZE17);
    assign row    = ROW_W'(ty_q - sy_sel);

    // Next-state logic for the slot walk. Swap has priority over start so a
    // coincident start is dropped.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        start     = 1'b0;
        load_addr = 1'b0;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((x == X_FETCH) && !swap) begin
                    start   = 1'b1;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hit) begin
                    load_addr = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    state_d   = S_NEXT;
                end
            end
            S_ISSUE: begin
                if (ROM_LAT > 1) begin
                    wait_d  = 2'(WAIT_INIT);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (wait_q == 2'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d  = wait_q - 2'd1;
                end
            end
            S_CAPTURE: begin
                capture = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                if (swap) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, snapshot, back buffer and front buffer registers. A swap in the
    // middle of a fetch flags overrun but lets the walk carry on, so its
    // remaining captures are shown on the following line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            wait_q        <= '0;
            armed_q       <= 1'b0;
            overrun_q     <= 1'b0;
            rom_addr_q    <= '0;
            ty_q          <= '0;
            en_q          <= '0;
            back_valid_q  <= '0;
            front_valid_q <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                sx_q[i]         <= '0;
                sy_q[i]         <= '0;
                img_q[i]        <= '0;
                back_data_q[i]  <= '0;
                back_x_q[i]     <= '0;
                front_data_q[i] <= '0;
                front_x_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;

            if (start) begin
                armed_q      <= 1'b1;
                ty_q         <= ty_next;
                en_q         <= sprite_en;
                back_valid_q <= '0;
                for (int i = 0; i < N_SPRITES; i++) begin
                    sx_q[i]  <= sprite_x[16*i +: 16];
                    sy_q[i]  <= sprite_y[16*i +: 16];
                    img_q[i] <= sprite_img[IMG_W*i +: IMG_W];
                end
            end

            if (load_addr) begin
                rom_addr_q <= {img_q[idx_q], row};
            end

            if (capture) begin
                back_data_q[idx_q]  <= rom_data;
                back_x_q[idx_q]     <= sx_q[idx_q];
                back_valid_q[idx_q] <= 1'b1;
            end

            if (swap) begin
                front_valid_q <= back_valid_q;
                for (int i = 0; i < N_SPRITES; i++) begin
                    front_data_q[i] <= back_data_q[i];
                    front_x_q[i]    <= back_x_q[i];
                end
                if ((state_q != S_IDLE) && (state_q != S_DONE)) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign rom_en     = (state_q == S_ISSUE);
    assign rom_addr   = rom_addr_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;
    assign line_valid = front_valid_q;

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_flat
        assign line_data[RW*g +: RW] = front_data_q[g];
        assign line_x[16*g +: 16]    = front_x_q[g];
    end

endmodule
